sm_dmem_arbiter: RTL and testbench

- Two-master arbiter that shares the single data-memory port (sr_ram) between the CPU data port (master 0) and a debug/loader port (master 1).
- Registered grant FSM with round-robin tie-break and a per-ownership hold limit.
- Muxes address, write data, size and sign onto the RAM.
- Registers RAM read data back to the granted master with a valid pulse.
- Sits between sr_cpu/debug logic and sr_ram in sm_top, clocked by the divided clk.

---
 rtl/sm_dmem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sm_dmem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_dmem_arbiter.sv
// Two-master arbiter for the shared data-memory port: CPU data port (m0) and debug/loader (m1).
// Optional build macro SM_DMEM_ARB_FIXED_PRIO_EN: m0 wins idle ties and is never forced off the port.
module sm_dmem_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned AW       = 32
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic          m0_we,
  input  logic [1:0]    m0_size,
  input  logic          m0_sign,
  output logic          m0_gnt,
  output logic [31:0]   m0_rdata,
  output logic          m0_rvalid,

  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic          m1_we,
  input  logic [1:0]    m1_size,
  input  logic          m1_sign,
  output logic          m1_gnt,
  output logic [31:0]   m1_rdata,
  output logic          m1_rvalid,

  output logic [AW-1:0] dm_addr,
  output logic [31:0]   dm_wdata,
  output logic          dm_we,
  output logic          dm_op_byte,
  output logic          dm_op_half,
  output logic          dm_op_word,
  output logic          dm_sign,
  input  logic [31:0]   dm_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

`ifdef SM_DMEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  localparam int unsigned    HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam bit             HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [HW-1:0]  HOLD_LAST = HOLD_EN ? HW'(MAX_HOLD - 1) : '0;

  state_t        state_q, state_d;
  logic          last_q, last_d;   // 0: m0 owned last, 1: m1 owned last
  logic [HW-1:0] hold_q, hold_d;

  logic          active0, active1;
  logic [1:0]    sel_size;

  assign active0 = (state_q == OWN0) && m0_req;
  assign active1 = (state_q == OWN1) && m1_req;

  // Next-state: release on owner drop, or forced handover once the hold budget is spent.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (m0_req && m1_req)
          state_d = (FIXED_PRIO || last_q) ? OWN0 : OWN1;
        else if (m0_req)
          state_d = OWN0;
        else if (m1_req)
          state_d = OWN1;
      end
      OWN0: begin
        if (!m0_req) begin
          last_d  = 1'b0;
          state_d = m1_req ? OWN1 : IDLE;
        end else if (HOLD_EN && !FIXED_PRIO && m1_req && (hold_q == HOLD_LAST)) begin
          last_d  = 1'b0;
          state_d = OWN1;
        end
      end
      OWN1: begin
        if (!m1_req) begin
          last_d  = 1'b1;
          state_d = m0_req ? OWN0 : IDLE;
        end else if (HOLD_EN && m0_req && (hold_q == HOLD_LAST)) begin
          last_d  = 1'b1;
          state_d = OWN0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Saturating count: with no contention the owner simply keeps the port.
    if (state_d != state_q)
      hold_d = '0;
    else if ((state_q != IDLE) && HOLD_EN && (hold_q != HOLD_LAST))
      hold_d = hold_q + HW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      hold_q  <= '0;
      m0_gnt  <= 1'b0;
      m1_gnt  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      m0_gnt  <= (state_d == OWN0);
      m1_gnt  <= (state_d == OWN1);
    end
  end

  // RAM-side mux; everything is held at zero unless the owner is actively requesting.
  always_comb begin
    dm_addr    = '0;
    dm_wdata   = '0;
    dm_we      = 1'b0;
    dm_sign    = 1'b0;
    sel_size   = 2'b00;
    dm_op_byte = 1'b0;
    dm_op_half = 1'b0;
    dm_op_word = 1'b0;
    if (active0) begin
      dm_addr  = m0_addr;
      dm_wdata = m0_wdata;
      dm_we    = m0_we;
      dm_sign  = m0_sign;
      sel_size = m0_size;
    end else if (active1) begin
      dm_addr  = m1_addr;
      dm_wdata = m1_wdata;
      dm_we    = m1_we;
      dm_sign  = m1_sign;
      sel_size = m1_size;
    end
    if (active0 || active1) begin
      case (sel_size)
        2'b00:   dm_op_byte = 1'b1;
        2'b01:   dm_op_half = 1'b1;
        default: dm_op_word = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= active0 && !m0_we;
      m1_rvalid <= active1 && !m1_we;
      if (active0 && !m0_we)
        m0_rdata <= dm_rdata;
      if (active1 && !m1_we)
        m1_rdata <= dm_rdata;
    end
  end

endmodule

// File: tb/tb_sm_dmem_arbiter.sv
// Self-checking bench for sm_dmem_arbiter: directed scenarios plus a randomized run
// against a cycle-level ownership model.
module tb_sm_dmem_arbiter;

  localparam int unsigned TB_HOLD = 8;
`ifdef SM_DMEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk, rst_n;
  logic        r_req [2];
  logic        r_we  [2];
  logic        r_sign[2];
  logic [1:0]  r_size[2];
  logic [31:0] r_addr[2];
  logic [31:0] r_wdata[2];

  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_we, dm_op_byte, dm_op_half, dm_op_word, dm_sign;

  logic [31:0] mem [16];
  assign dm_rdata = mem[dm_addr[5:2]];

  int checks;
  int errors;

  sm_dmem_arbiter #(.MAX_HOLD(TB_HOLD), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(r_req[0]), .m0_addr(r_addr[0]), .m0_wdata(r_wdata[0]), .m0_we(r_we[0]),
    .m0_size(r_size[0]), .m0_sign(r_sign[0]), .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
    .m0_rvalid(m0_rvalid),
    .m1_req(r_req[1]), .m1_addr(r_addr[1]), .m1_wdata(r_wdata[1]), .m1_we(r_we[1]),
    .m1_size(r_size[1]), .m1_sign(r_sign[1]), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
    .m1_rvalid(m1_rvalid),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_op_byte(dm_op_byte),
    .dm_op_half(dm_op_half), .dm_op_word(dm_op_word), .dm_sign(dm_sign), .dm_rdata(dm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_m(input int i, input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [1:0] size, input logic sign);
    r_req[i]   = req;
    r_we[i]    = we;
    r_addr[i]  = addr;
    r_wdata[i] = wd;
    r_size[i]  = size;
    r_sign[i]  = sign;
  endtask

  task automatic clear_all();
    set_m(0, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
    set_m(1, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_all();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin errors++; $display("FAIL rst_gnt got %b exp 00", {m0_gnt, m1_gnt}); end
    checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid got %b exp 00", {m0_rvalid, m1_rvalid}); end
    checks++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h/%h exp 0", m0_rdata, m1_rdata); end
    checks++; if ({dm_we, dm_op_byte, dm_op_half, dm_op_word, dm_sign} !== 5'b0 || dm_addr !== 32'h0 || dm_wdata !== 32'h0)
      begin errors++; $display("FAIL rst_dm got we=%b addr=%h exp all zero", dm_we, dm_addr); end
    set_m(0, 1'b1, 1'b1, 32'h40, 32'h1111, 2'b10, 1'b0);
    set_m(1, 1'b1, 1'b1, 32'h44, 32'h2222, 2'b10, 1'b0);
    @(negedge clk); #1;
    checks++; if ({m0_gnt, m1_gnt, dm_we} !== 3'b000) begin errors++; $display("FAIL rst_held got gnt/we %b exp 000", {m0_gnt, m1_gnt, dm_we}); end
    clear_all();
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    set_m(0, 1'b1, 1'b0, 32'h10, '0, 2'b10, 1'b0); #1;
    checks++; if (m0_gnt !== 1'b0) begin errors++; $display("FAIL rd_gnt_c0 got %b exp 0", m0_gnt); end
    @(negedge clk); #1;
    checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin errors++; $display("FAIL rd_gnt_c1 got %b%b exp 10", m0_gnt, m1_gnt); end
    checks++; if ({dm_op_byte, dm_op_half, dm_op_word} !== 3'b001) begin errors++; $display("FAIL rd_op got %b exp 001", {dm_op_byte, dm_op_half, dm_op_word}); end
    checks++; if (dm_addr !== 32'h10 || dm_we !== 1'b0) begin errors++; $display("FAIL rd_dm got addr %h we %b exp 10/0", dm_addr, dm_we); end
    @(negedge clk);
    set_m(0, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0); #1;
    checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got v=%b %h exp 1 deadbeef", m0_rvalid, m0_rdata); end
    checks++; if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0 || m1_gnt !== 1'b0) begin errors++; $display("FAIL rd_m1_quiet got v=%b d=%h g=%b exp 0", m1_rvalid, m1_rdata, m1_gnt); end
    @(negedge clk); #1;
    checks++; if (m0_rvalid !== 1'b0 || m0_gnt !== 1'b0) begin errors++; $display("FAIL rd_done got v=%b g=%b exp 0 0", m0_rvalid, m0_gnt); end
  endtask

  task automatic test_tie_handover();
    do_reset();
    set_m(0, 1'b1, 1'b0, 32'h4, '0, 2'b10, 1'b0);
    set_m(1, 1'b1, 1'b0, 32'h8, '0, 2'b10, 1'b0);
    @(negedge clk); #1;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL tie1 got %b exp 10", {m0_gnt, m1_gnt}); end
    @(negedge clk); #1;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL tie1_hold got %b exp 10", {m0_gnt, m1_gnt}); end
    @(negedge clk);
    r_req[0] = 1'b0; #1;
    checks++; if (m0_gnt !== 1'b1 || m0_rvalid !== 1'b1 || dm_we !== 1'b0 || dm_op_word !== 1'b0)
      begin errors++; $display("FAIL drop_cycle got g=%b v=%b we=%b w=%b exp 1 1 0 0", m0_gnt, m0_rvalid, dm_we, dm_op_word); end
    @(negedge clk); #1;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin errors++; $display("FAIL handover got %b exp 01", {m0_gnt, m1_gnt}); end
    checks++; if (m0_rvalid !== 1'b0 || dm_addr !== 32'h8) begin errors++; $display("FAIL handover_dm got v=%b addr=%h exp 0 8", m0_rvalid, dm_addr); end
    r_req[1] = 1'b0;
    @(negedge clk); #1;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin errors++; $display("FAIL idle_after got %b exp 00", {m0_gnt, m1_gnt}); end
    r_req[0] = 1'b1; r_req[1] = 1'b1;
    @(negedge clk); #1;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL tie2 got %b exp 10", {m0_gnt, m1_gnt}); end
    r_req[0] = 1'b0; r_req[1] = 1'b0;
    @(negedge clk); #1;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin errors++; $display("FAIL idle_after2 got %b exp 00", {m0_gnt, m1_gnt}); end
    r_req[0] = 1'b1; r_req[1] = 1'b1;
    @(negedge clk); #1;
    checks++; if ({m0_gnt, m1_gnt} !== {FIXED, !FIXED}) begin errors++; $display("FAIL tie3 got %b exp %b", {m0_gnt, m1_gnt}, {FIXED, !FIXED}); end
    clear_all();
  endtask

  task automatic test_hold_limit();
    int seq_g [40];
    bit seq_we [40];
    int k, run0, run1;
    do_reset();
    set_m(0, 1'b1, 1'b1, 32'h20, 32'hCAFE0000, 2'b10, 1'b0);
    set_m(1, 1'b1, 1'b0, 32'h24, '0, 2'b10, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      seq_g[i]  = m0_gnt ? 0 : (m1_gnt ? 1 : -1);
      seq_we[i] = dm_we;
      r_wdata[0] = r_wdata[0] + 32'd1;
    end
    k = 0; run0 = 0; run1 = 0;
    while (k < 40 && seq_g[k] == 0 && seq_we[k]) begin run0++; k++; end
    while (k < 40 && seq_g[k] == 1 && !seq_we[k]) begin run1++; k++; end
    checks++; if (run0 != TB_HOLD) begin errors++; $display("FAIL hold_m0_writes got %0d exp %0d", run0, TB_HOLD); end
    checks++; if (run1 != TB_HOLD) begin errors++; $display("FAIL hold_m1_run got %0d exp %0d", run1, TB_HOLD); end
    checks++; if (k >= 40 || seq_g[k] != 0) begin errors++; $display("FAIL hold_back_to_m0 at %0d exp owner 0", k); end
    clear_all();
  endtask

  task automatic test_fixed_prio();
    do_reset();
    set_m(0, 1'b1, 1'b0, 32'h30, '0, 2'b10, 1'b0);
    set_m(1, 1'b1, 1'b0, 32'h34, '0, 2'b10, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL fixed_hold cyc %0d got %b exp 10", i, {m0_gnt, m1_gnt}); end
    end
    r_req[0] = 1'b0;
    @(negedge clk); #1;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin errors++; $display("FAIL fixed_release got %b exp 01", {m0_gnt, m1_gnt}); end
    clear_all();
  endtask

  task automatic test_byte_write();
    int seen_rv, seen_we;
    do_reset();
    set_m(1, 1'b1, 1'b1, 32'h3, 32'hA5, 2'b00, 1'b0);
    @(negedge clk); #1;
    checks++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin errors++; $display("FAIL bw_gnt got %b%b exp 01", m0_gnt, m1_gnt); end
    checks++; if ({dm_op_byte, dm_op_half, dm_op_word} !== 3'b100 || dm_we !== 1'b1)
      begin errors++; $display("FAIL bw_op got ops %b we %b exp 100 1", {dm_op_byte, dm_op_half, dm_op_word}, dm_we); end
    checks++; if (dm_addr !== 32'h3 || dm_wdata !== 32'hA5) begin errors++; $display("FAIL bw_dm got %h %h exp 3 a5", dm_addr, dm_wdata); end
    r_req[1] = 1'b0;
    seen_rv = 0; seen_we = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      seen_rv += int'(m1_rvalid);
      seen_we += int'(dm_we);
    end
    checks++; if (seen_rv != 0 || seen_we != 0) begin errors++; $display("FAIL bw_after got rvalid %0d we %0d exp 0 0", seen_rv, seen_we); end
    clear_all();
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    set_m(1, 1'b1, 1'b0, 32'h8, '0, 2'b10, 1'b0);
    @(negedge clk); #1;
    checks++; if (m1_gnt !== 1'b1) begin errors++; $display("FAIL mr_gnt got %b exp 1", m1_gnt); end
    @(negedge clk);
    set_m(1, 1'b1, 1'b1, 32'hC, 32'h1234, 2'b10, 1'b0); #1;
    checks++; if (m1_rvalid !== 1'b1 || dm_we !== 1'b1) begin errors++; $display("FAIL mr_pre got v=%b we=%b exp 1 1", m1_rvalid, dm_we); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({dm_we, m1_gnt, m1_rvalid} !== 3'b000) begin errors++; $display("FAIL mr_async got we/gnt/rv %b exp 000", {dm_we, m1_gnt, m1_rvalid}); end
    @(negedge clk);
    clear_all();
    @(negedge clk);
    rst_n = 1'b1; #1;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin errors++; $display("FAIL mr_idle got %b exp 00", {m0_gnt, m1_gnt}); end
    r_req[0] = 1'b1; r_req[1] = 1'b1;
    @(negedge clk); #1;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL mr_tie got %b exp 10", {m0_gnt, m1_gnt}); end
    clear_all();
  endtask

  // Model: owner (-1 none), who released last, and granted cycles in the current tenure.
  task automatic test_random();
    int own, last, granted, o, x, nown;
    logic mrv[2], nrv[2];
    logic [31:0] mrd[2];
    logic act;
    logic [2:0] exp_ops;
    do_reset();
    own = -1; last = 1; granted = 0;
    mrv[0] = 1'b0; mrv[1] = 1'b0; mrd[0] = '0; mrd[1] = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (r_req[i]) begin
          if ($urandom_range(7) == 0) r_req[i] = 1'b0;
        end else if ($urandom_range(2) == 0) r_req[i] = 1'b1;
        r_we[i]    = 1'($urandom_range(1));
        r_addr[i]  = $urandom;
        r_wdata[i] = $urandom;
        r_size[i]  = 2'($urandom_range(3));
        r_sign[i]  = 1'($urandom_range(1));
      end
      #1;
      act = (own >= 0) && r_req[own];
      exp_ops = !act ? 3'b000 : (r_size[own] == 2'b00) ? 3'b100 : (r_size[own] == 2'b01) ? 3'b010 : 3'b001;
      checks++; if ({m0_gnt, m1_gnt} !== {own == 0, own == 1}) begin errors++; $display("FAIL rnd_gnt c%0d got %b exp owner %0d", c, {m0_gnt, m1_gnt}, own); end
      checks++; if ({m0_rvalid, m1_rvalid} !== {mrv[0], mrv[1]}) begin errors++; $display("FAIL rnd_rvalid c%0d got %b exp %b", c, {m0_rvalid, m1_rvalid}, {mrv[0], mrv[1]}); end
      checks++; if (m0_rdata !== mrd[0] || m1_rdata !== mrd[1]) begin errors++; $display("FAIL rnd_rdata c%0d got %h/%h exp %h/%h", c, m0_rdata, m1_rdata, mrd[0], mrd[1]); end
      checks++; if (dm_we !== (act && r_we[own])) begin errors++; $display("FAIL rnd_we c%0d got %b exp %b", c, dm_we, act && r_we[own]); end
      checks++; if ({dm_op_byte, dm_op_half, dm_op_word} !== exp_ops) begin errors++; $display("FAIL rnd_ops c%0d got %b exp %b", c, {dm_op_byte, dm_op_half, dm_op_word}, exp_ops); end
      if (act) begin
        checks++; if (dm_addr !== r_addr[own] || dm_wdata !== r_wdata[own] || dm_sign !== r_sign[own])
          begin errors++; $display("FAIL rnd_mux c%0d got %h %h %b exp %h %h %b", c, dm_addr, dm_wdata, dm_sign, r_addr[own], r_wdata[own], r_sign[own]); end
      end else if (own < 0) begin
        checks++; if (dm_addr !== 32'h0 || dm_wdata !== 32'h0) begin errors++; $display("FAIL rnd_idle_dm c%0d got %h %h exp 0", c, dm_addr, dm_wdata); end
      end
      @(posedge clk);
      o = own;
      nrv[0] = 1'b0; nrv[1] = 1'b0;
      if (o >= 0 && r_req[o] && !r_we[o]) begin
        mrd[o] = mem[r_addr[o][5:2]];
        nrv[o] = 1'b1;
      end
      mrv = nrv;
      nown = o;
      if (o < 0) begin
        if (r_req[0] && r_req[1]) nown = (FIXED || last == 1) ? 0 : 1;
        else if (r_req[0]) nown = 0;
        else if (r_req[1]) nown = 1;
      end else begin
        x = 1 - o;
        if (!r_req[o]) begin
          last = o;
          nown = r_req[x] ? x : -1;
        end else if (granted >= int'(TB_HOLD) && r_req[x] && !(FIXED && o == 0)) begin
          last = o;
          nown = x;
        end
      end
      if (nown != o) granted = (nown >= 0) ? 1 : 0;
      else if (o >= 0) granted++;
      own = nown;
      @(negedge clk);
    end
    clear_all();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    clear_all();
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[4] = 32'hDEADBEEF;

    test_reset();
    test_single_read();
    test_tie_handover();
`ifdef SM_DMEM_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_hold_limit();
`endif
    test_byte_write();
    test_reset_mid_access();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
